// File: rtl/sudoku_check_sequencer.sv
// sudoku_check_sequencer
// Walks the 27 Sudoku constraint groups (9 rows, 9 columns, 9 boxes) through
// a single synchronous read port. Each returned cell is checked against a
// per-group seen-mask. The first violating group is recorded, and blank cells
// are tracked through the full flag.
module sudoku_check_sequencer #(
  parameter int RD_LAT     = 1,     // grid store read latency, 1..2
  parameter bit EARLY_EXIT = 1'b1   // stop issuing reads after the first error
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       rd_en,
  output logic [3:0] rd_row,
  output logic [3:0] rd_col,
  input  logic [3:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_group,
  output logic [3:0] err_index,
  output logic       full
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Small lookup tables replace any divide/modulo by 3.
  function automatic logic [3:0] div3(input logic [3:0] x);
    case (x)
      4'd0, 4'd1, 4'd2: div3 = 4'd0;
      4'd3, 4'd4, 4'd5: div3 = 4'd1;
      4'd6, 4'd7, 4'd8: div3 = 4'd2;
      default:          div3 = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] mod3(input logic [3:0] x);
    case (x)
      4'd0, 4'd3, 4'd6: mod3 = 4'd0;
      4'd1, 4'd4, 4'd7: mod3 = 4'd1;
      4'd2, 4'd5, 4'd8: mod3 = 4'd2;
      default:          mod3 = 4'd0;
    endcase
  endfunction

  // Map (group type, group index, cell index) to a packed {row, col} address.
  function automatic logic [7:0] cell_addr(input logic [1:0] g, input logic [3:0] k,
                                           input logic [3:0] c);
    logic [3:0] br;
    logic [3:0] bc;
    br = div3(k) + div3(k) + div3(k) + div3(c);
    bc = mod3(k) + mod3(k) + mod3(k) + mod3(c);
    case (g)
      2'd0:    cell_addr = {k, c};
      2'd1:    cell_addr = {c, k};
      2'd2:    cell_addr = {br, bc};
      default: cell_addr = {k, c};
    endcase
  endfunction

  state_t     state_q, state_d;
  logic       rd_en_q, rd_en_d;
  logic [3:0] rd_row_q, rd_row_d;
  logic [3:0] rd_col_q, rd_col_d;
  logic [1:0] g_q, g_d;
  logic [3:0] k_q, k_d;
  logic [3:0] c_q, c_d;
  logic [8:0] mask_q, mask_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [1:0] err_group_q, err_group_d;
  logic [3:0] err_index_q, err_index_d;
  logic       full_q, full_d;
  // Tag layout: {valid, g[1:0], k[3:0], last}
  logic [7:0] tag_q [RD_LAT];
  logic [7:0] tag_d [RD_LAT];

  logic [7:0] head_s;
  logic       inflight_s;
  logic       viol_s;
  logic [8:0] onehot_s;
  logic [8:0] mask_upd_s;
  logic       last_issue_s;
  logic [7:0] addr_s;

  // Next-state logic: tag pipeline, cell check, error capture and scan FSM.
  always_comb begin
    state_d     = state_q;
    rd_en_d     = rd_en_q;
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;
    g_d         = g_q;
    k_d         = k_q;
    c_d         = c_q;
    mask_d      = mask_q;
    done_d      = done_q;
    err_d       = err_q;
    err_group_d = err_group_q;
    err_index_d = err_index_q;
    full_d      = full_q;
    viol_s      = 1'b0;
    onehot_s    = 9'd0;
    mask_upd_s  = mask_q;
    addr_s      = 8'd0;

    // Tags shift one stage per cycle so the head lines up with rd_data.
    tag_d[0] = {rd_en_q, g_q, k_q, (c_q == 4'd8)};
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    head_s     = tag_q[RD_LAT-1];
    inflight_s = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_s = inflight_s | tag_q[i][7];
    end

    // Check the returned cell; the last cell of a group flags first, then clears.
    if (head_s[7]) begin
      if (rd_data == 4'd0) begin
        full_d = 1'b0;
      end else if (rd_data <= 4'd9) begin
        onehot_s   = 9'd1 << (rd_data - 4'd1);
        viol_s     = ((mask_q & onehot_s) != 9'd0);
        mask_upd_s = mask_q | onehot_s;
      end else begin
        viol_s = 1'b1;
        full_d = 1'b0;
      end
      mask_d = head_s[0] ? 9'd0 : mask_upd_s;
    end else begin
      mask_d = mask_q;
    end

    // Only the first violation is recorded.
    if (viol_s && !err_q) begin
      err_d       = 1'b1;
      err_group_d = head_s[6:5];
      err_index_d = head_s[4:1];
    end else begin
      err_d = err_q;
    end

    last_issue_s = (g_q == 2'd2) && (k_q == 4'd8) && (c_q == 4'd8);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_ISSUE;
          rd_en_d     = 1'b1;
          rd_row_d    = 4'd0;
          rd_col_d    = 4'd0;
          g_d         = 2'd0;
          k_d         = 4'd0;
          c_d         = 4'd0;
          mask_d      = 9'd0;
          done_d      = 1'b0;
          err_d       = 1'b0;
          err_group_d = 2'd3;
          err_index_d = 4'd15;
          full_d      = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_ISSUE: begin
        if (last_issue_s || (EARLY_EXIT && (viol_s || err_q))) begin
          state_d = S_DRAIN;
          rd_en_d = 1'b0;
        end else begin
          if (c_q == 4'd8) begin
            c_d = 4'd0;
            if (k_q == 4'd8) begin
              k_d = 4'd0;
              g_d = g_q + 2'd1;
            end else begin
              k_d = k_q + 4'd1;
            end
          end else begin
            c_d = c_q + 4'd1;
          end
          addr_s   = cell_addr(g_d, k_d, c_d);
          rd_row_d = addr_s[7:4];
          rd_col_d = addr_s[3:0];
          rd_en_d  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (!inflight_s) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
        rd_en_d = 1'b0;
      end
    endcase

    // Abort cancels everything, including reads still in flight.
    if (abort) begin
      state_d     = S_IDLE;
      rd_en_d     = 1'b0;
      rd_row_d    = 4'd0;
      rd_col_d    = 4'd0;
      mask_d      = 9'd0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_group_d = 2'd3;
      err_index_d = 4'd15;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_d[i] = 8'd0;
      end
    end else begin
      state_d = state_d;
    end

    busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
  end

  // State and registered outputs, asynchronously cleared by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_en_q     <= 1'b0;
      rd_row_q    <= 4'd0;
      rd_col_q    <= 4'd0;
      g_q         <= 2'd0;
      k_q         <= 4'd0;
      c_q         <= 4'd0;
      mask_q      <= 9'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_group_q <= 2'd3;
      err_index_q <= 4'd15;
      full_q      <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= 8'd0;
      end
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      g_q         <= g_d;
      k_q         <= k_d;
      c_q         <= c_d;
      mask_q      <= mask_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_group_q <= err_group_d;
      err_index_q <= err_index_d;
      full_q      <= full_d;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_row    = rd_row_q;
  assign rd_col    = rd_col_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_group = err_group_q;
  assign err_index = err_index_q;
  assign full      = full_q;

endmodule
